// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the 4:1 data mux.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping around to 'last' itself.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  // Scan last+1 .. last+4; the 2-bit add wraps naturally, so the final probe is 'last'.
  always_comb begin
    logic [SEL_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + SEL_W'(i);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of the shared 4:1 data mux; grant is held until the owner releases.
// Define MUX_ARB_TIMEOUT_EN to add a MAX_HOLD cycle limit that forces rotation when others wait.
module mux_rr_arbiter
  import mux_arb_pkg::*;
`ifdef MUX_ARB_TIMEOUT_EN
#(
  parameter int MAX_HOLD = 8
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] in,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             out
);

  arb_state_t       state_q, state_d;
  logic [N_REQ-1:0] gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             busy_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] pick_winner;
  logic             pick_valid;
  logic [SEL_W-1:0] win_idx;
  logic             owner_req;
  logic             take;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             time_up;

  assign time_up = (cnt_q == CNT_W'(MAX_HOLD - 1));
`endif

  // The current owner is masked out so a rotation always lands on somebody else.
  rr_pick u_pick (
    .req    (req & ~gnt),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  assign win_idx   = onehot_to_idx(pick_winner);
  assign owner_req = |(req & gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      last_q  <= SEL_W'(N_REQ - 1);
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      last_q  <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // A release hands over in the same edge; only an empty request set drops back to IDLE.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    last_d  = last_q;
    take    = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: take = pick_valid;
      GRANT: begin
        if (!owner_req) begin
          take = pick_valid;
          if (!pick_valid) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (time_up) begin
          take  = pick_valid;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = GRANT;
      gnt_d   = pick_winner;
      sel_d   = win_idx;
      busy_d  = 1'b1;
      last_d  = win_idx;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
  end

  always_comb begin
    out = busy ? in[sel] : 1'b0;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter; follows MUX_ARB_TIMEOUT_EN the same way the design does.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       out;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       out;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   owner_cycles;

  logic [3:0] m_gnt;
  logic [1:0] m_sel;
  logic [1:0] m_last;
  logic       m_busy;
  int         m_cnt;

  mux_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .in    (in),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_gnt  = 4'b0000;
    m_sel  = 2'd0;
    m_last = 2'd3;
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  // Behavioural reference: one call per rising edge, given the request vector that edge samples.
  task automatic modelStep(input logic [3:0] r);
    int   owner;
    int   pick;
    int   idx;
    logic holds;
    logic time_up;
    owner = m_busy ? int'(m_sel) : -1;
    holds = m_busy && r[m_sel];
`ifdef MUX_ARB_TIMEOUT_EN
    time_up = holds && (m_cnt == MAX_HOLD - 1);
`else
    time_up = 1'b0;
`endif
    if (holds && !time_up) begin
      m_cnt++;
    end else begin
      pick = -1;
      for (int i = 1; i <= 4; i++) begin
        idx = (int'(m_last) + i) % 4;
        if (pick < 0 && r[idx] && idx != owner) pick = idx;
      end
      m_cnt = 0;
      if (pick >= 0) begin
        m_gnt  = 4'(1 << pick);
        m_sel  = 2'(pick);
        m_last = 2'(pick);
        m_busy = 1'b1;
      end else if (!holds) begin
        m_gnt  = 4'b0000;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want a pending entry");
      return;
    end
    e = sb.pop_front();
    check("gnt",  8'(gnt),  8'(e.gnt));
    check("sel",  8'(sel),  8'(e.sel));
    check("busy", 8'(busy), 8'(e.busy));
    check("out",  8'(out),  8'(e.out));
  endtask

  // Drive on the falling edge, predict the next rising edge, compare just after it.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d);
    exp_t e;
    @(negedge clk);
    req = r;
    in  = d;
    modelStep(r);
    e.gnt  = m_gnt;
    e.sel  = m_sel;
    e.busy = m_busy;
    e.out  = m_busy ? d[m_sel] : 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    #2;
    rst_n = 1'b0;
    req   = 4'b0000;
    in    = 4'b1111;
    #1;
    check("rst_gnt",  8'(gnt),  8'h00);
    check("rst_sel",  8'(sel),  8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_out",  8'(out),  8'h00);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] m;
    rst_n = 1'b0;
    req   = 4'b0000;
    in    = 4'b1111;
    modelReset();
    doReset();

    // Single request, then a one-cycle request.
    applyStimulus(4'b0000, 4'b0100);
    applyStimulus(4'b0100, 4'b0100);
    check("single_gnt", 8'(gnt), 8'h04);
    check("single_out", 8'(out), 8'h01);
    applyStimulus(4'b0100, 4'b0100);
    applyStimulus(4'b0000, 4'b0100);
    applyStimulus(4'b1000, 4'b1000);
    applyStimulus(4'b0000, 4'b1000);
    applyStimulus(4'b0000, 4'b1000);

    // All four requesting from reset, each owner releasing after 3 grant cycles.
    doReset();
    m = 4'b1111;
    applyStimulus(m, 4'b1010);
    check("order_first", 8'(gnt), 8'h01);
    for (int o = 0; o < 4; o++) begin
      applyStimulus(m, 4'b1010);
      applyStimulus(m, 4'b1010);
      m = m & ~4'(1 << o);
      applyStimulus(m, 4'b1010);
      if (o < 3) check("order_next", 8'(gnt), 8'(1 << (o + 1)));
      else       check("order_idle", 8'(gnt), 8'h00);
    end

    // Wrap fairness from last=3.
    applyStimulus(4'b1001, 4'b0001);
    check("wrap_first", 8'(gnt), 8'h01);
    applyStimulus(4'b1001, 4'b0001);
    applyStimulus(4'b1000, 4'b1000);
    check("wrap_second", 8'(gnt), 8'h08);
    applyStimulus(4'b0000, 4'b0000);

    // Long hold by requester 0 with requester 2 waiting from the third cycle.
    owner_cycles = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c < 2) ? 4'b0001 : 4'b0101, 4'b0001);
      if (gnt == 4'b0001) owner_cycles++;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    check("hold_cycles", 8'(owner_cycles), 8'd8);
    check("hold_gnt", 8'(gnt), 8'h04);
`else
    check("hold_cycles", 8'(owner_cycles), 8'd12);
    check("hold_gnt", 8'(gnt), 8'h01);
`endif
    applyStimulus(4'b0100, 4'b0100);
    applyStimulus(4'b0000, 4'b0000);

    // Data gating.
    applyStimulus(4'b0000, 4'b1111);
    check("idle_out", 8'(out), 8'h00);
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0010);
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b1101);
    applyStimulus(4'b0010, 4'b1111);
    in = 4'b1101;
    #1;
    check("comb_out_low", 8'(out), 8'h00);
    in = 4'b0010;
    #1;
    check("comb_out_high", 8'(out), 8'h01);

    // Reset while requester 1 owns the mux, then re-grant.
    check("pre_reset_gnt", 8'(gnt), 8'h02);
    doReset();
    applyStimulus(4'b0010, 4'b0010);
    check("regrant_gnt", 8'(gnt), 8'h02);
    check("regrant_sel", 8'(sel), 8'h01);
    applyStimulus(4'b0000, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
